alu_issue_stage: RTL and testbench

- ID/EX boundary register that sits directly upstream of the ALU.
- Accepts decoded instructions over a valid/ready handshake and resolves rs1/rs2 by forwarding from the instruction currently in EX and from the writeback bus.
- Selects the operands and presents control, op1 and op2 to the ALU from registered state.
- A one-entry skid buffer gives a fully registered o_ready, so a downstream stall does not combinationally reach decode.

---
 rtl/alu_issue_stage_pkg.sv | 24 ++
 rtl/alu_issue_stage_fwd_sel.sv | 43 ++++
 rtl/alu_issue_stage.sv | 194 +++++++++++++++++++
 tb/tb_alu_issue_stage.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_stage_pkg.sv
// ---------------------------------------------------------------------------
// alu_issue_stage_pkg
//   Shared definitions for the ALU issue stage: default datapath/register
//   address widths, the ALU control field width and the ALU opcode encodings
//   presented on o_alu_ctrl.
// ---------------------------------------------------------------------------
package alu_issue_stage_pkg;

    localparam int XLEN_DEF = 32;
    localparam int RAW_DEF  = 5;
    localparam int CTRL_W   = 4;

    localparam logic [CTRL_W-1:0] ALU_ADD  = 4'h0;
    localparam logic [CTRL_W-1:0] ALU_SLL  = 4'h1;
    localparam logic [CTRL_W-1:0] ALU_SLT  = 4'h2;
    localparam logic [CTRL_W-1:0] ALU_SLTU = 4'h3;
    localparam logic [CTRL_W-1:0] ALU_XOR  = 4'h4;
    localparam logic [CTRL_W-1:0] ALU_SRL  = 4'h5;
    localparam logic [CTRL_W-1:0] ALU_OR   = 4'h6;
    localparam logic [CTRL_W-1:0] ALU_AND  = 4'h7;
    localparam logic [CTRL_W-1:0] ALU_SUB  = 4'h8;
    localparam logic [CTRL_W-1:0] ALU_SRA  = 4'hd;

endpackage

// File: rtl/alu_issue_stage_fwd_sel.sv
// ---------------------------------------------------------------------------
// alu_issue_stage_fwd_sel
//   Combinational source-operand resolver. Priority, highest first:
//   x0 -> 0, instruction in EX -> ex_result, writeback bus -> wb_data,
//   otherwise the register-file read data.
//
//   addr      : source register address
//   rf_data   : register-file read data for addr
//   ex_en     : EX entry is valid and writes its rd
//   ex_rd     : EX entry destination register
//   ex_result : ALU result of the EX entry
//   wb_we/wb_addr/wb_data : writeback bus
//   data      : resolved operand value
// ---------------------------------------------------------------------------
module alu_issue_stage_fwd_sel
    import alu_issue_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int RAW  = RAW_DEF
) (
    input  logic [RAW-1:0]  addr,
    input  logic [XLEN-1:0] rf_data,
    input  logic            ex_en,
    input  logic [RAW-1:0]  ex_rd,
    input  logic [XLEN-1:0] ex_result,
    input  logic            wb_we,
    input  logic [RAW-1:0]  wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] data
);

    always_comb begin
        data = rf_data;
        if (addr == '0) begin
            data = '0;
        end else if (ex_en && (ex_rd == addr)) begin
            data = ex_result;
        end else if (wb_we && (wb_addr == addr)) begin
            data = wb_data;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
//   ID/EX boundary register in front of the ALU. Decoded instructions are
//   accepted over valid/ready, their sources are resolved by forwarding from
//   the entry currently in EX and from the writeback bus, and the held entry
//   drives the ALU directly from registers. A one-entry skid buffer keeps
//   o_ready fully registered.
//
//   i_clk, i_rst_n        : clock, async active-low reset
//   i_flush               : synchronous kill of both held entries
//   i_valid / o_ready     : upstream handshake (o_ready registered)
//   i_alu_ctrl ... i_rd_we: decoded instruction fields
//   i_ex_result           : ALU result of the entry presented on o_*
//   i_wb_we/addr/data     : writeback bus, used for forwarding and snooping
//   o_valid / i_ready     : downstream handshake
//   o_alu_ctrl, o_op1/2   : ALU control and operands
//   o_rd_addr, o_rd_we    : destination travelling with the entry
// ---------------------------------------------------------------------------
module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int RAW  = RAW_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_flush,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [CTRL_W-1:0] i_alu_ctrl,
    input  logic [RAW-1:0]    i_rs1_addr,
    input  logic [RAW-1:0]    i_rs2_addr,
    input  logic [XLEN-1:0]   i_rs1_data,
    input  logic [XLEN-1:0]   i_rs2_data,
    input  logic [XLEN-1:0]   i_imm,
    input  logic              i_use_imm,
    input  logic              i_use_pc,
    input  logic [XLEN-1:0]   i_pc,
    input  logic [RAW-1:0]    i_rd_addr,
    input  logic              i_rd_we,
    input  logic [XLEN-1:0]   i_ex_result,
    input  logic              i_wb_we,
    input  logic [RAW-1:0]    i_wb_addr,
    input  logic [XLEN-1:0]   i_wb_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [CTRL_W-1:0] o_alu_ctrl,
    output logic [XLEN-1:0]   o_op1,
    output logic [XLEN-1:0]   o_op2,
    output logic [RAW-1:0]    o_rd_addr,
    output logic              o_rd_we
);

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [RAW-1:0]    rs1_addr;
        logic [RAW-1:0]    rs2_addr;
        logic [XLEN-1:0]   rs1_val;
        logic [XLEN-1:0]   rs2_val;
        logic [XLEN-1:0]   imm;
        logic              use_imm;
        logic              use_pc;
        logic [XLEN-1:0]   pc;
        logic [RAW-1:0]    rd;
        logic              rd_we;
    } entry_t;

    entry_t          main_p1, skid_p1;
    entry_t          main_nxt, skid_nxt, new_p0;
    logic            vld_p1, skid_vld_p1, rdy_p1;
    logic            vld_nxt, skid_vld_nxt;
    logic            accept, depart, ex_en;
    logic [XLEN-1:0] rs1_fwd, rs2_fwd;

    // A held entry picks up any writeback to one of its sources so it never
    // presents a value older than the register file. x0 is never updated.
    function automatic entry_t snoop(input entry_t e, input logic we,
                                     input logic [RAW-1:0] a,
                                     input logic [XLEN-1:0] d);
        entry_t r;
        r = e;
        if (we && (a != '0) && (a == e.rs1_addr)) r.rs1_val = d;
        if (we && (a != '0) && (a == e.rs2_addr)) r.rs2_val = d;
        return r;
    endfunction

    // ---- stage p0: capture-side operand resolution ----
    assign accept = i_valid && rdy_p1;
    assign depart = vld_p1 && i_ready;
    // EX forwarding uses main even when it departs this cycle; while main is
    // stalled its result is stable, so a skid capture of i_ex_result is safe.
    assign ex_en  = vld_p1 && main_p1.rd_we;

    alu_issue_stage_fwd_sel #(.XLEN(XLEN), .RAW(RAW)) u_fwd_rs1 (
        .addr      (i_rs1_addr),
        .rf_data   (i_rs1_data),
        .ex_en     (ex_en),
        .ex_rd     (main_p1.rd),
        .ex_result (i_ex_result),
        .wb_we     (i_wb_we),
        .wb_addr   (i_wb_addr),
        .wb_data   (i_wb_data),
        .data      (rs1_fwd)
    );

    alu_issue_stage_fwd_sel #(.XLEN(XLEN), .RAW(RAW)) u_fwd_rs2 (
        .addr      (i_rs2_addr),
        .rf_data   (i_rs2_data),
        .ex_en     (ex_en),
        .ex_rd     (main_p1.rd),
        .ex_result (i_ex_result),
        .wb_we     (i_wb_we),
        .wb_addr   (i_wb_addr),
        .wb_data   (i_wb_data),
        .data      (rs2_fwd)
    );

    always_comb begin
        new_p0          = '0;
        new_p0.ctrl     = i_alu_ctrl;
        new_p0.rs1_addr = i_rs1_addr;
        new_p0.rs2_addr = i_rs2_addr;
        new_p0.rs1_val  = rs1_fwd;
        new_p0.rs2_val  = rs2_fwd;
        new_p0.imm      = i_imm;
        new_p0.use_imm  = i_use_imm;
        new_p0.use_pc   = i_use_pc;
        new_p0.pc       = i_pc;
        new_p0.rd       = i_rd_addr;
        new_p0.rd_we    = i_rd_we;
    end

    always_comb begin
        main_nxt     = main_p1;
        skid_nxt     = skid_p1;
        vld_nxt      = vld_p1;
        skid_vld_nxt = skid_vld_p1;
        if (vld_p1)      main_nxt = snoop(main_p1, i_wb_we, i_wb_addr, i_wb_data);
        if (skid_vld_p1) skid_nxt = snoop(skid_p1, i_wb_we, i_wb_addr, i_wb_data);

        if (i_flush) begin
            vld_nxt      = 1'b0;
            skid_vld_nxt = 1'b0;
        end else if (depart) begin
            // o_ready is low whenever skid is full, so accept cannot coincide
            // with a skid-to-main move.
            if (skid_vld_p1) begin
                main_nxt     = skid_nxt;
                skid_vld_nxt = 1'b0;
            end else if (accept) begin
                main_nxt = new_p0;
            end else begin
                vld_nxt = 1'b0;
            end
        end else if (accept) begin
            if (!vld_p1) begin
                main_nxt = new_p0;
                vld_nxt  = 1'b1;
            end else begin
                skid_nxt     = new_p0;
                skid_vld_nxt = 1'b1;
            end
        end
    end

    // ---- stage p1: main/skid registers ----
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_p1      <= 1'b0;
            skid_vld_p1 <= 1'b0;
            rdy_p1      <= 1'b1;
            main_p1     <= '0;
        end else begin
            vld_p1      <= vld_nxt;
            skid_vld_p1 <= skid_vld_nxt;
            rdy_p1      <= !skid_vld_nxt;
            main_p1     <= main_nxt;
        end
    end

    // Skid contents are only meaningful under skid_vld_p1.
    always_ff @(posedge i_clk) begin
        skid_p1 <= skid_nxt;
    end

    assign o_ready    = rdy_p1;
    assign o_valid    = vld_p1;
    assign o_alu_ctrl = main_p1.ctrl;
    assign o_op1      = main_p1.use_pc  ? main_p1.pc  : main_p1.rs1_val;
    assign o_op2      = main_p1.use_imm ? main_p1.imm : main_p1.rs2_val;
    assign o_rd_addr  = main_p1.rd;
    assign o_rd_we    = main_p1.rd_we;

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;
    import alu_issue_stage_pkg::*;

    localparam int XLEN = 32;
    localparam int RAW  = 5;

    logic              i_clk = 1'b0;
    logic              i_rst_n;
    logic              i_flush;
    logic              i_valid;
    logic              o_ready;
    logic [CTRL_W-1:0] i_alu_ctrl;
    logic [RAW-1:0]    i_rs1_addr, i_rs2_addr;
    logic [XLEN-1:0]   i_rs1_data, i_rs2_data;
    logic [XLEN-1:0]   i_imm;
    logic              i_use_imm, i_use_pc;
    logic [XLEN-1:0]   i_pc;
    logic [RAW-1:0]    i_rd_addr;
    logic              i_rd_we;
    logic [XLEN-1:0]   i_ex_result;
    logic              i_wb_we;
    logic [RAW-1:0]    i_wb_addr;
    logic [XLEN-1:0]   i_wb_data;
    logic              o_valid;
    logic              i_ready;
    logic [CTRL_W-1:0] o_alu_ctrl;
    logic [XLEN-1:0]   o_op1, o_op2;
    logic [RAW-1:0]    o_rd_addr;
    logic              o_rd_we;

    int n_cmp = 0;
    int n_err = 0;

    alu_issue_stage #(.XLEN(XLEN), .RAW(RAW)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush),
        .i_valid(i_valid), .o_ready(o_ready), .i_alu_ctrl(i_alu_ctrl),
        .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr),
        .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data),
        .i_imm(i_imm), .i_use_imm(i_use_imm), .i_use_pc(i_use_pc), .i_pc(i_pc),
        .i_rd_addr(i_rd_addr), .i_rd_we(i_rd_we), .i_ex_result(i_ex_result),
        .i_wb_we(i_wb_we), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
        .o_valid(o_valid), .i_ready(i_ready), .o_alu_ctrl(o_alu_ctrl),
        .o_op1(o_op1), .o_op2(o_op2), .o_rd_addr(o_rd_addr), .o_rd_we(o_rd_we)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send(input logic [3:0] ctrl, input int r1, input int d1,
                        input int r2, input int d2, input int rd, input logic we);
        i_valid    = 1'b1;
        i_alu_ctrl = ctrl;
        i_rs1_addr = r1[4:0];
        i_rs1_data = d1;
        i_rs2_addr = r2[4:0];
        i_rs2_data = d2;
        i_rd_addr  = rd[4:0];
        i_rd_we    = we;
        i_use_imm  = 1'b0;
        i_use_pc   = 1'b0;
        i_imm      = '0;
        i_pc       = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst_n = 1'b0; i_flush = 1'b0; i_ready = 1'b1;
        i_ex_result = '0; i_wb_we = 1'b0; i_wb_addr = '0; i_wb_data = '0;
        send(ALU_ADD, 0, 0, 0, 0, 0, 1'b0);
        i_valid = 1'b0;
        repeat (2) tick();
        check_eq("rst_vld",  32'(o_valid), 32'd0);
        check_eq("rst_rdy",  32'(o_ready), 32'd1);
        check_eq("rst_op1",  o_op1, 32'd0);
        check_eq("rst_op2",  o_op2, 32'd0);
        check_eq("rst_ctrl", 32'(o_alu_ctrl), 32'd0);
        i_rst_n = 1'b1;
        tick();

        // single ADD x3 = x1 + x2
        send(ALU_ADD, 1, 5, 2, 7, 3, 1'b1);
        tick();
        i_valid = 1'b0;
        check_eq("t1_vld",  32'(o_valid), 32'd1);
        check_eq("t1_op1",  o_op1, 32'd5);
        check_eq("t1_op2",  o_op2, 32'd7);
        check_eq("t1_ctrl", 32'(o_alu_ctrl), 32'd0);
        check_eq("t1_rd",   32'(o_rd_addr), 32'd3);
        check_eq("t1_rdy",  32'(o_ready), 32'd1);
        tick();
        check_eq("t1_drain", 32'(o_valid), 32'd0);

        // back-to-back dependent: SUB x4 = x3 - x2, x3 forwarded from EX
        send(ALU_ADD, 1, 5, 2, 7, 3, 1'b1);
        tick();
        send(ALU_SUB, 3, 0, 2, 7, 4, 1'b1);
        i_ex_result = 32'd12;
        tick();
        i_valid = 1'b0;
        i_ex_result = '0;
        check_eq("t2_vld",  32'(o_valid), 32'd1);
        check_eq("t2_op1",  o_op1, 32'd12);
        check_eq("t2_op2",  o_op2, 32'd7);
        check_eq("t2_ctrl", 32'(o_alu_ctrl), 32'd8);
        tick();

        // WB forward at capture, then EX priority over WB
        send(ALU_ADD, 20, 0, 0, 0, 21, 1'b1);
        i_wb_we = 1'b1; i_wb_addr = 5'd20; i_wb_data = 32'h55;
        tick();
        check_eq("t2b_wb", o_op1, 32'h55);
        send(ALU_ADD, 21, 1, 0, 0, 22, 1'b0);
        i_wb_addr = 5'd21; i_wb_data = 32'h77; i_ex_result = 32'h99;
        tick();
        i_valid = 1'b0; i_wb_we = 1'b0; i_ex_result = '0;
        check_eq("t2b_pri", o_op1, 32'h99);
        tick();

        // downstream stall: A in main, B in skid, C waits
        i_ready = 1'b0;
        send(ALU_XOR, 6, 100, 7, 200, 8, 1'b0);
        tick();
        check_eq("t3_a_op1", o_op1, 32'd100);
        check_eq("t3_rdy1",  32'(o_ready), 32'd1);
        send(ALU_OR, 6, 101, 7, 201, 9, 1'b0);
        tick();
        check_eq("t3_rdy0",  32'(o_ready), 32'd0);
        check_eq("t3_hold",  o_op1, 32'd100);
        send(ALU_AND, 6, 102, 7, 202, 10, 1'b0);
        tick();
        check_eq("t3_still_rdy", 32'(o_ready), 32'd0);
        check_eq("t3_still_op1", o_op1, 32'd100);
        i_ready = 1'b1;
        tick();
        check_eq("t3_b_op1",  o_op1, 32'd101);
        check_eq("t3_b_ctrl", 32'(o_alu_ctrl), 32'd6);
        check_eq("t3_b_rdy",  32'(o_ready), 32'd1);
        tick();
        i_valid = 1'b0;
        check_eq("t3_c_op1",  o_op1, 32'd102);
        check_eq("t3_c_op2",  o_op2, 32'd202);
        check_eq("t3_c_ctrl", 32'(o_alu_ctrl), 32'd7);
        tick();
        check_eq("t3_empty", 32'(o_valid), 32'd0);

        // WB snoop into held skid entry
        i_ready = 1'b0;
        send(ALU_ADD, 9, 1, 10, 2, 11, 1'b0);
        tick();
        send(ALU_ADD, 12, 3, 5, 0, 13, 1'b0);
        tick();
        i_valid = 1'b0;
        i_wb_we = 1'b1; i_wb_addr = 5'd5; i_wb_data = 32'hDEAD;
        tick();
        i_wb_we = 1'b0;
        tick();
        check_eq("t4_a_op2", o_op2, 32'd2);
        i_ready = 1'b1;
        tick();
        check_eq("t4_op2", o_op2, 32'hDEAD);
        check_eq("t4_op1", o_op1, 32'd3);
        tick();
        check_eq("t4_empty", 32'(o_valid), 32'd0);

        // x0 source and immediate operand, x0 never snooped
        i_ready = 1'b0;
        send(ALU_ADD, 0, 32'h1234, 0, 32'h5678, 14, 1'b1);
        i_use_imm = 1'b1; i_imm = 32'hFFFFF800;
        i_wb_we = 1'b1; i_wb_addr = 5'd0; i_wb_data = 32'hFFFF;
        tick();
        i_valid = 1'b0;
        tick();
        i_wb_we = 1'b0;
        check_eq("t5_op1", o_op1, 32'd0);
        check_eq("t5_op2", o_op2, 32'hFFFFF800);
        i_ready = 1'b1;
        tick();
        send(ALU_ADD, 1, 5, 0, 0, 15, 1'b0);
        i_use_pc = 1'b1; i_pc = 32'h1000;
        tick();
        i_valid = 1'b0; i_use_pc = 1'b0;
        check_eq("t5_pc", o_op1, 32'h1000);
        tick();

        // flush with both entries full; concurrent i_valid discarded
        i_ready = 1'b0;
        send(ALU_ADD, 1, 1, 2, 2, 3, 1'b0);
        tick();
        send(ALU_ADD, 1, 2, 2, 2, 3, 1'b0);
        tick();
        check_eq("t6_full_rdy", 32'(o_ready), 32'd0);
        send(ALU_ADD, 1, 3, 2, 2, 3, 1'b0);
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        i_valid = 1'b0;
        check_eq("t6_vld", 32'(o_valid), 32'd0);
        check_eq("t6_rdy", 32'(o_ready), 32'd1);
        tick();
        check_eq("t6_gone", 32'(o_valid), 32'd0);
        i_ready = 1'b1;
        send(ALU_ADD, 1, 32'h44, 2, 2, 3, 1'b0);
        tick();
        i_valid = 1'b0;
        check_eq("t6_recover", o_op1, 32'h44);
        tick();

        // async reset asserted mid-stall
        i_ready = 1'b0;
        send(ALU_ADD, 1, 7, 2, 8, 3, 1'b0);
        tick();
        send(ALU_ADD, 1, 9, 2, 8, 3, 1'b0);
        tick();
        #2;
        i_rst_n = 1'b0;
        #1;
        check_eq("t7_vld", 32'(o_valid), 32'd0);
        check_eq("t7_rdy", 32'(o_ready), 32'd1);
        check_eq("t7_op1", o_op1, 32'd0);
        check_eq("t7_op2", o_op2, 32'd0);
        tick();
        i_rst_n = 1'b1;
        i_valid = 1'b0;
        tick();
        check_eq("t7_after", 32'(o_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
